// File: rtl/sl_transmitter_if.sv
// Word handshake between the APB-side feeder and the SL transmitter.
// SL_TX_PARITY_ERR_INJ_EN adds the parityInvert request bit.
interface sl_transmitter_if;
    logic [31:0] dataIn;
    logic [4:0]  bitCount;
    logic        wordValid;
    logic        wordReady;
`ifdef SL_TX_PARITY_ERR_INJ_EN
    logic        parityInvert;

    modport master (output dataIn, bitCount, wordValid, parityInvert, input wordReady);
    modport slave  (input dataIn, bitCount, wordValid, parityInvert, output wordReady);
`else
    modport master (output dataIn, bitCount, wordValid, input wordReady);
    modport slave  (input dataIn, bitCount, wordValid, output wordReady);
`endif
endinterface

// File: rtl/sl_transmitter.sv
// Serial-line word transmitter: bit pulses on sl0/sl1, then parity and stop marker.
// Optional SL_TX_PARITY_ERR_INJ_EN: parityInvert latched at acceptance flips the parity phase.
module sl_transmitter #(
    parameter int unsigned PHASE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    sl_transmitter_if.slave  wordIf,
    output logic             wordInProces,
    output logic             txDone,
    output logic             sl0,
    output logic             sl1
);

    typedef enum logic [2:0] {
        IDLE, BIT_LOW, BIT_HIGH, PARITY, POST_PAR, STOP, POST_STOP
    } state_t;

    localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYCLES - 1);

    state_t      state;
    logic [31:0] shiftReg;
    logic [4:0]  bitsLeft;
    logic [7:0]  phaseCnt;
    logic        par0;
    logic        par1;
    logic        parInv;
    logic        parInvIn;
    logic        accept;

`ifdef SL_TX_PARITY_ERR_INJ_EN
    assign parInvIn = wordIf.parityInvert;
`else
    assign parInvIn = 1'b0;
`endif

    assign wordIf.wordReady = enable && (state == IDLE);
    assign accept           = wordIf.wordValid && wordIf.wordReady;

    // Line levels are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            shiftReg     <= '0;
            bitsLeft     <= '0;
            phaseCnt     <= '0;
            par0         <= 1'b0;
            par1         <= 1'b0;
            parInv       <= 1'b0;
            sl0          <= 1'b1;
            sl1          <= 1'b1;
            wordInProces <= 1'b0;
            txDone       <= 1'b0;
        end else begin
            txDone <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    shiftReg     <= wordIf.dataIn;
                    bitsLeft     <= wordIf.bitCount;
                    parInv       <= parInvIn;
                    par0         <= 1'b1;
                    par1         <= 1'b0;
                    phaseCnt     <= PHASE_LAST;
                    state        <= BIT_LOW;
                    sl0          <= wordIf.dataIn[0];
                    sl1          <= ~wordIf.dataIn[0];
                    wordInProces <= 1'b1;
                end
            end else if (phaseCnt != 8'd0) begin
                phaseCnt <= phaseCnt - 8'd1;
                // Pulse lands on the final cycle of the frame (counter reaches 0 next).
                if (state == POST_STOP && phaseCnt == 8'd1) txDone <= 1'b1;
            end else begin
                phaseCnt <= PHASE_LAST;
                case (state)
                    BIT_LOW: begin
                        state <= BIT_HIGH;
                        sl0   <= 1'b1;
                        sl1   <= 1'b1;
                        if (shiftReg[0]) par1 <= ~par1;
                        else             par0 <= ~par0;
                    end
                    BIT_HIGH: begin
                        shiftReg <= {1'b0, shiftReg[31:1]};
                        if (bitsLeft != 5'd0) begin
                            bitsLeft <= bitsLeft - 5'd1;
                            state    <= BIT_LOW;
                            sl0      <= shiftReg[1];
                            sl1      <= ~shiftReg[1];
                        end else begin
                            state <= PARITY;
                            sl0   <= par0 ^ parInv;
                            sl1   <= par1 ^ parInv;
                        end
                    end
                    PARITY: begin
                        state <= POST_PAR;
                        sl0   <= 1'b1;
                        sl1   <= 1'b1;
                    end
                    POST_PAR: begin
                        state <= STOP;
                        sl0   <= 1'b0;
                        sl1   <= 1'b0;
                    end
                    STOP: begin
                        state <= POST_STOP;
                        sl0   <= 1'b1;
                        sl1   <= 1'b1;
                    end
                    default: begin
                        state        <= IDLE;
                        sl0          <= 1'b1;
                        sl1          <= 1'b1;
                        wordInProces <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sl_transmitter.md
# sl_transmitter

Serial-line (SL) word transmitter. It serialises a parallel word of 1–32 bits onto the two-wire sl0/sl1 bus. Each bit is a low pulse on sl0 (data 0) or sl1 (data 1), followed by a parity phase and a stop marker. It sits directly upstream of the SL receiver, so its output must be bit-exact with what the receiver decodes. It is fed from the APB side through a valid/ready handshake.

## Interface
Parameters:
- PHASE_CYCLES, 4: clock cycles per line phase; legal range 2–255.

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  permits acceptance of new words; does not abort a word in flight
- dataIn  in  32  word to send; dataIn[0] is transmitted first
- bitCount  in  5  word length minus one (0 → 1 bit, 31 → 32 bits)
- wordValid  in  1  upstream has a word on dataIn/bitCount
- wordReady  out  1  block can accept a word this cycle
- wordInProces  out  1  high from acceptance until the end of the last phase
- txDone  out  1  one-cycle pulse on the last cycle of the final phase
- sl0  out  1  SL line 0; idles high
- sl1  out  1  SL line 1; idles high

## Operation
- Acceptance: a word is taken on a rising edge where wordValid && wordReady. dataIn and bitCount are latched into a shift register and a bit counter. Input changes after acceptance have no effect.
- wordReady = enable && state==IDLE (combinational from registered state).
- Parity accumulators on acceptance: par0=1, par1=0. Each transmitted 0 toggles par0; each transmitted 1 toggles par1.
- FSM states; every non-IDLE state lasts exactly PHASE_CYCLES cycles, timed by a phase down-counter:
  - IDLE: sl0=1, sl1=1. Goes to BIT_LOW on acceptance.
  - BIT_LOW: the line selected by the current bit is 0, the other is 1. Goes to BIT_HIGH.
  - BIT_HIGH: both lines 1; the shift register advances. Goes to BIT_LOW if bits remain, else to PARITY.
  - PARITY: sl0=par0, sl1=par1. Goes to POST_PAR.
  - POST_PAR: both lines 1. Goes to STOP.
  - STOP: both lines 0. Goes to POST_STOP.
  - POST_STOP: both lines 1; txDone on its last cycle. Goes to IDLE.
- Frame length: 2·(bitCount+1)+4 phases.
- enable falling mid-word: the word completes normally; no new word is accepted.
- Reset (including mid-word): at the next edge, state=IDLE, sl0=sl1=1, wordInProces=0, txDone=0, counters and accumulators cleared. No partial frame is resumed.

## Timing
- Reset values: sl0=1, sl1=1, wordInProces=0, txDone=0, and wordReady=enable.
- sl0, sl1, wordInProces and txDone are registered.
- Acceptance on edge N: the first BIT_LOW level appears on sl0/sl1 in the cycle after edge N, and wordInProces rises at the same time.
- Word duration: (2·(bitCount+1)+4)·PHASE_CYCLES cycles from acceptance until IDLE.
- txDone is high in the final cycle. IDLE, and wordReady if enabled, follow on the next cycle.
- Back-to-back: with wordValid held high, the next word is accepted in the first IDLE cycle. The gap between frames is exactly 1 cycle of idle-high.

## Configuration
- SL_TX_PARITY_ERR_INJ_EN defined: adds input port parityInvert (1 bit), latched at acceptance. When the latched value is 1, the PARITY phase drives sl0=!par0 and sl1=!par1; all other phases are unchanged.
- Undefined: the port is absent and parity is always correct.

## Test plan
- Reset, PHASE_CYCLES=4, dataIn=0x000000A5, bitCount=7, wordValid pulse:
  - Low pulses appear on sl1,sl0,sl1,sl0,sl0,sl1,sl0,sl1, each 4 cycles long.
  - PARITY phase gives sl0=1, sl1=0, then a STOP phase of both lines 0.
  - txDone fires 80 cycles after acceptance.
- dataIn=0xFFFFFFFF, bitCount=31:
  - 32 pulses on sl1, none on sl0.
  - PARITY phase gives sl0=1, sl1=0.
  - Frame length is 272 cycles.
- bitCount=0, dataIn[0]=1:
  - One sl1 pulse.
  - PARITY phase gives sl0=1, sl1=1.
  - Frame length is 24 cycles.
- wordValid held high with two queued words:
  - wordReady is high for exactly 1 cycle between frames.
  - Second frame's first BIT_LOW starts 2 cycles after the first frame's txDone cycle.
- reset_n low for 1 cycle mid-BIT_LOW:
  - Next cycle gives sl0=sl1=1, wordInProces=0, wordReady=enable.
  - A new word then transmits correctly.
- With SL_TX_PARITY_ERR_INJ_EN, 0xA5, bitCount=7, parityInvert=1: PARITY phase gives sl0=0, sl1=1. The SL receiver's parityValid reads 0.
